systolic_gemm_tile: RTL and testbench

SYSTOLIC_GEMM_TILE -- requirements
Module: systolic_gemm_tile

---
 rtl/systolic_gemm_tile.sv | 202 ++++++++++++++++++++
 tb/tb_systolic_gemm_tile.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_gemm_tile.sv
// Output-stationary ROWSxCOLS systolic GEMM tile (C += A*B over cfg_k beats); optional SYSTOLIC_SAT_EN saturates accumulators.
// Latency: first result row cfg_k+ROWS+COLS cycles after start with unstalled input; one row per cycle in drain.
// Backpressure: in_ready only in FEED (bubbles inject zeros); drain holds row while out_ready is low.
module systolic_gemm_tile #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int K_W    = 8
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic [K_W-1:0]                            cfg_k,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [ROWS*DATA_W-1:0]                    in_a,
  input  logic [COLS*DATA_W-1:0]                    in_b,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [COLS*ACC_W-1:0]                     out_row,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row_idx,
  output logic                                      busy,
  output logic                                      done
);
  localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FL_W  = $clog2(ROWS + COLS);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_FLUSH, S_DRAIN} state_t;

  state_t           state, state_n;
  logic [K_W-1:0]   k_q, beat_cnt;
  logic [FL_W-1:0]  flush_cnt;
  logic [IDX_W-1:0] row_idx;
  logic             start_ok, beat, row_acc, adv, clr, last_row;

  logic signed [DATA_W-1:0] a_h   [ROWS][COLS];
  logic signed [DATA_W-1:0] b_h   [ROWS][COLS];
  logic signed [ACC_W-1:0]  acc_w [ROWS][COLS];

  assign in_ready    = (state == S_FEED);
  assign out_valid   = (state == S_DRAIN);
  assign busy        = (state != S_IDLE);
  assign out_row_idx = row_idx;
  assign adv         = (state == S_FEED) || (state == S_FLUSH);
  assign clr         = start_ok;
  assign last_row    = (row_idx == IDX_W'(ROWS - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    state_n  = state;
    start_ok = 1'b0;
    beat     = 1'b0;
    row_acc  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && (cfg_k != '0)) begin
          start_ok = 1'b1;
          state_n  = S_FEED;
        end
      end
      S_FEED: begin
        beat = in_valid;
        if (in_valid && (beat_cnt == k_q - K_W'(1))) state_n = S_FLUSH;
      end
      S_FLUSH: begin
        if (flush_cnt == FL_W'(ROWS + COLS - 2)) state_n = S_DRAIN;
      end
      S_DRAIN: begin
        if (out_ready) begin
          row_acc = 1'b1;
          if (last_row) state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Beat/flush/row counters, latched K and the done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_q       <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      row_idx   <= '0;
      done      <= 1'b0;
    end else begin
      done <= row_acc && last_row;
      if (start_ok) begin
        k_q       <= cfg_k;
        beat_cnt  <= '0;
        flush_cnt <= '0;
        row_idx   <= '0;
      end
      if (beat)              beat_cnt  <= beat_cnt + K_W'(1);
      if (state == S_FLUSH)  flush_cnt <= flush_cnt + FL_W'(1);
      if (row_acc)           row_idx   <= last_row ? '0 : row_idx + IDX_W'(1);
    end
  end

  // West edge: lane r delayed r cycles so operands of one beat meet on the anti-diagonal
  for (genvar r = 0; r < ROWS; r++) begin : g_askew
    logic signed [DATA_W-1:0] a_new;
    assign a_new = beat ? in_a[r*DATA_W +: DATA_W] : '0;
    if (r == 0) begin : g_direct
      assign a_h[r][0] = a_new;
    end else begin : g_dly
      logic signed [DATA_W-1:0] sk [r];
      // Skew shift register, advances with the array
      always_ff @(posedge clk or posedge reset) begin
        if (reset || clr) begin
          for (int s = 0; s < r; s++) sk[s] <= '0;
        end else if (adv) begin
          sk[0] <= a_new;
          for (int s = 1; s < r; s++) sk[s] <= sk[s-1];
        end
      end
      assign a_h[r][0] = sk[r-1];
    end
  end

  // North edge: lane c delayed c cycles
  for (genvar c = 0; c < COLS; c++) begin : g_bskew
    logic signed [DATA_W-1:0] b_new;
    assign b_new = beat ? in_b[c*DATA_W +: DATA_W] : '0;
    if (c == 0) begin : g_direct
      assign b_h[0][c] = b_new;
    end else begin : g_dly
      logic signed [DATA_W-1:0] sk [c];
      // Skew shift register, advances with the array
      always_ff @(posedge clk or posedge reset) begin
        if (reset || clr) begin
          for (int s = 0; s < c; s++) sk[s] <= '0;
        end else if (adv) begin
          sk[0] <= b_new;
          for (int s = 1; s < c; s++) sk[s] <= sk[s-1];
        end
      end
      assign b_h[0][c] = sk[c-1];
    end
  end

  // Processing elements
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_pe
      logic signed [2*DATA_W-1:0] prod;
      logic signed [ACC_W-1:0]    prod_x, acc_q, acc_n;
      assign prod   = (2*DATA_W)'(a_h[r][c]) * (2*DATA_W)'(b_h[r][c]);
      assign prod_x = ACC_W'(prod);
`ifdef SYSTOLIC_SAT_EN
      logic signed [ACC_W:0] sum_x;
      assign sum_x = (ACC_W+1)'(acc_q) + (ACC_W+1)'(prod_x);
      // Clamp when the extra sum bit disagrees with the result sign
      always_comb begin
        acc_n = sum_x[ACC_W-1:0];
        if (sum_x[ACC_W] != sum_x[ACC_W-1])
          acc_n = sum_x[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
`else
      assign acc_n = acc_q + prod_x;
`endif
      // Accumulator, cleared at tile start
      always_ff @(posedge clk or posedge reset) begin
        if (reset || clr) acc_q <= '0;
        else if (adv)     acc_q <= acc_n;
      end
      assign acc_w[r][c] = acc_q;

      if (c < COLS - 1) begin : g_apass
        logic signed [DATA_W-1:0] a_q;
        // Eastward operand hop
        always_ff @(posedge clk or posedge reset) begin
          if (reset || clr) a_q <= '0;
          else if (adv)     a_q <= a_h[r][c];
        end
        assign a_h[r][c+1] = a_q;
      end
      if (r < ROWS - 1) begin : g_bpass
        logic signed [DATA_W-1:0] b_q;
        // Southward operand hop
        always_ff @(posedge clk or posedge reset) begin
          if (reset || clr) b_q <= '0;
          else if (adv)     b_q <= b_h[r][c];
        end
        assign b_h[r+1][c] = b_q;
      end
    end
  end

  // Result row mux, zero whenever no row is being offered
  always_comb begin
    out_row = '0;
    if (out_valid)
      for (int c = 0; c < COLS; c++) out_row[c*ACC_W +: ACC_W] = acc_w[row_idx][c];
  end
endmodule

// File: tb/tb_systolic_gemm_tile.sv
module tb_systolic_gemm_tile;
  localparam int R = 4;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         reset, start, in_valid, out_ready;
  logic [7:0]   cfg_k;
  logic [31:0]  in_a, in_b;
  logic         in_ready, out_valid, busy, done;
  logic [127:0] out_row;
  logic [1:0]   out_row_idx;
  logic         in_ready_h, out_valid_h, busy_h, done_h;
  logic [63:0]  out_row_h;
  logic [1:0]   out_row_idx_h;

  systolic_gemm_tile #(.DATA_W(8), .ACC_W(32), .ROWS(R), .COLS(C), .K_W(8)) u_dut (
    .clk(clk), .reset(reset), .start(start), .cfg_k(cfg_k), .in_valid(in_valid),
    .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_row(out_row), .out_row_idx(out_row_idx),
    .busy(busy), .done(done));

  systolic_gemm_tile #(.DATA_W(8), .ACC_W(16), .ROWS(R), .COLS(C), .K_W(8)) u_d16 (
    .clk(clk), .reset(reset), .start(start), .cfg_k(cfg_k), .in_valid(in_valid),
    .in_ready(in_ready_h), .in_a(in_a), .in_b(in_b), .out_valid(out_valid_h),
    .out_ready(out_ready), .out_row(out_row_h), .out_row_idx(out_row_idx_h),
    .busy(busy_h), .done(done_h));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int ba [64][R];
  int bb [64][C];
  logic [127:0] q32 [$];
  logic [63:0]  q16 [$];
  logic [1:0]   qi  [$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint acc_step(input longint acc, input longint p, input int w);
    longint s, hi, lo, m;
    s  = acc + p;
    m  = longint'(1) << w;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -hi - 1;
`ifdef SYSTOLIC_SAT_EN
    if (s > hi) s = hi;
    if (s < lo) s = lo;
`else
    s = s & (m - 1);
    if (s > hi) s = s - m;
`endif
    return s;
  endfunction

  task automatic push_expected(input int k);
    logic [127:0] row32;
    logic [63:0]  row16;
    longint a32, a16;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        a32 = 0;
        a16 = 0;
        for (int b = 0; b < k; b++) begin
          a32 = acc_step(a32, longint'(ba[b][r] * bb[b][c]), 32);
          a16 = acc_step(a16, longint'(ba[b][r] * bb[b][c]), 16);
        end
        row32[c*32 +: 32] = a32[31:0];
        row16[c*16 +: 16] = a16[15:0];
      end
      q32.push_back(row32);
      q16.push_back(row16);
      qi.push_back(2'(r));
    end
  endtask

  task automatic fill_const(input int k, input int a, input int b);
    for (int i = 0; i < k; i++) begin
      for (int r = 0; r < R; r++) ba[i][r] = a;
      for (int c = 0; c < C; c++) bb[i][c] = b;
    end
  endtask

  task automatic fill_rand(input int k);
    for (int i = 0; i < k; i++) begin
      for (int r = 0; r < R; r++) ba[i][r] = int'($urandom_range(255)) - 128;
      for (int c = 0; c < C; c++) bb[i][c] = int'($urandom_range(255)) - 128;
    end
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic run_tile(input int k, input bit bubble, input int stall_row,
                          input bit timing_chk, input bit junk);
    int c0, got, t, rows, stall, first_vld;
    start = 1'b1;
    cfg_k = 8'(k);
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    push_expected(k);
    got = 0;
    t = 0;
    while (got < k && t < 300) begin
      in_valid = bubble ? (t % 2 == 0) : 1'b1;
      for (int r = 0; r < R; r++) in_a[r*8 +: 8] = 8'(ba[got][r]);
      for (int c = 0; c < C; c++) in_b[c*8 +: 8] = 8'(bb[got][c]);
      if (in_valid && in_ready) got++;
      @(negedge clk);
      t++;
    end
    if (got < k) chk("feed_timeout", got, k);
    in_valid = junk;
    in_a = junk ? $urandom : 32'h0;
    in_b = junk ? $urandom : 32'h0;
    chk("in_ready_flush", in_ready, 1'b0);
    rows = 0;
    t = 0;
    stall = 0;
    first_vld = -1;
    while (rows < R && t < 300) begin
      if (out_valid && first_vld < 0) first_vld = cyc - c0;
      if (out_valid && int'(out_row_idx) == stall_row && stall < 5 && q32.size() > 0) begin
        out_ready = 1'b0;
        stall++;
        chk("stall_row_hold", out_row, q32[0]);
        chk("stall_idx_hold", out_row_idx, qi[0]);
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready && q32.size() > 0) begin
        chk("row32", out_row, q32.pop_front());
        chk("row16", out_row_h, q16.pop_front());
        chk("row_idx", out_row_idx, qi.pop_front());
        rows++;
      end
      if (junk) begin
        start = 1'b1;
        cfg_k = 8'd3;
      end
      @(negedge clk);
      t++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    if (rows < R) chk("drain_timeout", rows, R);
    chk("done_pulse", done, 1'b1);
    chk("idle_after_drain", busy, 1'b0);
    if (timing_chk) begin
      chk("first_out_cycle", first_vld, k + R + C);
      chk("done_cycle", cyc - c0, k + R + C + R);
    end
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    cfg_k = '0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_out_row", out_row, 128'h0);
    chk("rst_out_idx", out_row_idx, 2'd0);
    reset = 1'b0;

    // first start right after reset release, all ones, timing
    fill_const(4, 1, 1);
    run_tile(4, 1'b0, -1, 1'b1, 1'b0);

    // start with zero K is ignored
    start = 1'b1;
    cfg_k = 8'd0;
    @(negedge clk);
    start = 1'b0;
    chk("zero_k_ignored", busy, 1'b0);
    chk("zero_k_in_ready", in_ready, 1'b0);

    // signed operands
    fill_const(2, -3, 5);
    run_tile(2, 1'b0, -1, 1'b1, 1'b0);

    // continuous versus bubbled input
    fill_const(3, 2, 3);
    run_tile(3, 1'b0, -1, 1'b1, 1'b0);
    run_tile(3, 1'b1, -1, 1'b0, 1'b0);

    // random lanes, output stall on row 1, junk in_valid/start outside FEED
    fill_rand(5);
    run_tile(5, 1'b1, 1, 1'b0, 1'b1);

    // overflow behaviour on the 16-bit instance
    fill_const(3, 127, 127);
    run_tile(3, 1'b0, -1, 1'b1, 1'b0);

    // reset in the middle of FEED
    start = 1'b1;
    cfg_k = 8'd3;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_a = {4{8'd5}};
    in_b = {4{8'd7}};
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b0);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_out_row", out_row, 128'h0);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b0;
    fill_const(1, 1, 1);
    run_tile(1, 1'b0, -1, 1'b1, 1'b0);

    chk("queue_empty", q32.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
